psum_writeback: RTL and testbench

- Read-side partner of the corelet output FIFO: drains accumulated partial-sum rows whenever the FIFO reports valid.
- Optionally applies ReLU per lane, then writes each row as one word into the psum SRAM at consecutive addresses.
- Sits between the corelet output and the psum memory; one pass per output tile, started by the top-level controller.

---
 rtl/psum_writeback.sv | 132 +++++++++++++
 tb/tb_psum_writeback.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback.sv
// Drains accumulated partial-sum rows from the corelet output FIFO, applies
// optional per-lane ReLU, and writes one row per word into the psum SRAM.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int nij_len = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [col*psum_bw-1:0]   mem_d,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int cnt_w = $clog2(nij_len + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(nij_len - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(nij_len);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [addr_bw-1:0]     base_q;
  logic                   relu_q;
  logic [cnt_w-1:0]       rd_cnt;
  logic [cnt_w-1:0]       wr_cnt;
  logic                   wr_pending;
  logic                   accept;
  logic                   last_write;
  logic [col*psum_bw-1:0] relu_row;

  always_comb begin
    relu_row = ofifo_out;
    for (int j = 0; j < col; j++) begin
      if (relu_q && ofifo_out[j*psum_bw + psum_bw - 1]) begin
        relu_row[j*psum_bw +: psum_bw] = '0;
      end
    end
  end

  // True when the final write of the pass is on the bus this cycle (or has
  // already retired), so DONE follows a single FLUSH cycle.
  assign last_write = (wr_pending && (wr_cnt == cnt_last)) ||
                      (!wr_pending && (wr_cnt == cnt_full));

  // FIFO handshake: a row moves on every rising edge where ofifo_valid and
  // ofifo_rd are both high; ofifo_rd is only raised while ofifo_valid is high.
  always_comb begin
    state_nxt = state;
    ofifo_rd  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ofifo_rd = ofifo_valid && (rd_cnt < cnt_full);
        if (ofifo_rd && (rd_cnt == cnt_last)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (last_write) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_q     <= '0;
      relu_q     <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      wr_pending <= 1'b0;
      mem_addr   <= '0;
      mem_d      <= '0;
    end else begin
      state      <= state_nxt;
      wr_pending <= ofifo_rd;
      if (accept) begin
        base_q <= base_addr;
        relu_q <= relu_en;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (wr_pending) begin
        wr_cnt <= wr_cnt + cnt_w'(1);
      end
      // Writes retire in pop order, so the pop index is the write index.
      if (ofifo_rd) begin
        rd_cnt   <= rd_cnt + cnt_w'(1);
        mem_addr <= base_q + addr_bw'(rd_cnt);
        mem_d    <= relu_row;
      end
    end
  end

  assign mem_cen   = ~wr_pending;
  assign mem_wen   = ~wr_pending;
  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: randomized FIFO supply, a pass-level
// behavioural model with an expected-write queue, and literal spot checks.
module tb_psum_writeback;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int AW  = 11;
  localparam int NIJ = 16;
  localparam int DW  = COL * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          relu_en;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_out;
  logic          ofifo_rd;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  psum_writeback #(.col(COL), .psum_bw(PW), .addr_bw(AW), .nij_len(NIJ)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int dut_pops  = 0;
  int dut_dones = 0;

  logic [DW-1:0]    src_q[$];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    wr_log[$];
  logic [DW-1:0]    wd_log[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] row, input bit r);
    logic [DW-1:0] o;
    logic signed [PW-1:0] lane;
    o = row;
    for (int j = 0; j < COL; j++) begin
      lane = row[j*PW +: PW];
      if (r && lane < 0) o[j*PW +: PW] = '0;
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] seq_row(input int k);
    logic [DW-1:0] o;
    for (int j = 0; j < COL; j++) o[j*PW +: PW] = PW'(k * COL + j);
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural model ----------------
  bit            m_active = 0;
  bit            m_flush  = 0;
  bit            m_done   = 0;
  bit            m_wr     = 0;
  int            m_popped = 0;
  logic [AW-1:0] m_base   = '0;
  bit            m_relu   = 0;
  bit            m_rd;
  bit            m_acc;

  function automatic bit exp_rd();
    return reset && m_active && (m_popped < NIJ) && ofifo_valid;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_flush = 0; m_done = 0; m_wr = 0; m_popped = 0;
      m_base = '0; m_relu = 0;
      exp_q.delete();
    end else begin
      m_rd  = exp_rd();
      m_acc = start && !m_active && !m_done;
      m_done = m_flush;
      if (m_flush) m_active = 0;
      m_flush = 0;
      m_wr = m_rd;
      if (m_rd) begin
        exp_q.push_back({AW'(m_base + m_popped), relu_f(ofifo_out, m_relu)});
        if (src_q.size() > 0) void'(src_q.pop_front());
        m_popped++;
        if (m_popped == NIJ) m_flush = 1;
      end
      if (m_acc) begin
        m_active = 1; m_popped = 0; m_base = base_addr; m_relu = relu_en;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [AW-1:0]    h_addr = '0;
  logic [DW-1:0]    h_data = '0;
  logic [AW+DW-1:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      h_addr = '0;
      h_data = '0;
    end else if (m_wr) begin
      chk("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        h_addr = e[AW+DW-1:DW];
        h_data = e[DW-1:0];
      end
    end
    chk("ofifo_rd", ofifo_rd, exp_rd());
    chk("mem_cen", mem_cen, !m_wr);
    chk("mem_wen", mem_wen, !m_wr);
    chk("mem_addr", mem_addr, h_addr);
    chk("mem_d", mem_d, h_data);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    if (ofifo_rd) dut_pops++;
    if (done) dut_dones++;
    if (!mem_cen) begin
      wr_log.push_back(mem_addr);
      wd_log.push_back(mem_d);
    end
  end

  // ---------------- FIFO driver ----------------
  int gate_mode = 0;
  int pat_i     = 0;
  int pat[6]    = '{1, 0, 0, 1, 1, 0};
  bit g;

  always @(posedge clk) begin
    #2;
    case (gate_mode)
      1:       g = (pat[pat_i % 6] != 0);
      2:       g = ($urandom_range(0, 1) == 1);
      default: g = 1;
    endcase
    pat_i++;
    if (src_q.size() > 0 && g) begin
      ofifo_valid = 1'b1;
      ofifo_out   = src_q[0];
    end else begin
      ofifo_valid = 1'b0;
      ofifo_out   = rand_row();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_pass(input logic [AW-1:0] b, input bit r, input int mode,
                          input bit restart, input bit done_start);
    int pops0, dones0, cyc;
    bit got;
    wr_log.delete();
    wd_log.delete();
    pops0 = dut_pops;
    dones0 = dut_dones;
    gate_mode = mode;
    @(posedge clk); #1;
    base_addr = b; relu_en = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    relu_en = 1'($urandom);
    cyc = 0;
    got = 0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (restart && cyc == 4) || (done_start && m_done);
      if (restart && cyc == 4) base_addr = 11'h100;
      if (dut_dones != dones0) got = 1;
    end
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pass_done", got, 1);
    chk("pass_pops", dut_pops - pops0, NIJ);
    chk("pass_dones", dut_dones - dones0, 1);
    chk("pass_writes", wr_log.size(), NIJ);
    for (int i = 0; i < wr_log.size(); i++) chk("wr_addr_contig", wr_log[i], AW'(b + i));
    src_q.delete();
  endtask

  task automatic fill_seq(input int n, input int off);
    for (int k = 0; k < n; k++) src_q.push_back(seq_row(k + off));
  endtask

  // ---------------- main sequence ----------------
  logic [PW-1:0] relu_in_l[8]  = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h8001, 16'h0005, 16'hC000};
  logic [PW-1:0] relu_exp_l[8] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0005, 16'h0000};
  logic [DW-1:0] relu_in;
  logic [DW-1:0] relu_exp;
  int            pops_before;
  int            cyc;

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; relu_en = 1'b0;
    ofifo_valid = 1'b0; ofifo_out = '0;
    for (int j = 0; j < COL; j++) begin
      relu_in[j*PW +: PW]  = relu_in_l[j];
      relu_exp[j*PW +: PW] = relu_exp_l[j];
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Pin the model's ReLU against hand-computed lanes.
    chk("model_relu_on", relu_f(relu_in, 1), relu_exp);
    chk("model_relu_off", relu_f(relu_in, 0), relu_in);

    // Continuous drain.
    fill_seq(NIJ, 0);
    run_pass(11'h040, 1'b0, 0, 1'b0, 1'b0);
    if (wr_log.size() == NIJ) begin
      chk("cont_first_addr", wr_log[0], 11'h040);
      chk("cont_last_addr", wr_log[15], 11'h04F);
      chk("cont_row5", wd_log[5], seq_row(5));
    end

    // ReLU lanes.
    src_q.push_back(relu_in);
    for (int k = 1; k < NIJ; k++) src_q.push_back(rand_row());
    run_pass(11'h300, 1'b1, 0, 1'b0, 1'b0);
    if (wd_log.size() > 0) chk("relu_row_literal", wd_log[0], relu_exp);

    // Bubbly valid.
    fill_seq(NIJ, 20);
    run_pass(11'h123, 1'b0, 1, 1'b0, 1'b0);

    // Over-supply plus start while busy.
    fill_seq(30, 40);
    run_pass(11'h040, 1'b0, 0, 1'b1, 1'b0);
    if (wr_log.size() == NIJ) begin
      chk("busy_start_first", wr_log[0], 11'h040);
      chk("busy_start_last", wr_log[15], 11'h04F);
    end

    // Address wrap, with start pulsed in the DONE cycle.
    fill_seq(NIJ, 80);
    run_pass(11'h7FC, 1'b0, 0, 1'b0, 1'b1);
    if (wr_log.size() == NIJ) begin
      chk("wrap_top", wr_log[3], 11'h7FF);
      chk("wrap_zero", wr_log[4], 11'h000);
      chk("wrap_last", wr_log[15], 11'h00B);
    end
    chk("done_start_idle", busy, 1'b0);

    // Reset mid-pass after 7 pops.
    fill_seq(NIJ, 100);
    gate_mode = 0;
    pops_before = dut_pops;
    @(posedge clk); #1;
    base_addr = 11'h155; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (m_popped < 7 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_pops_before", dut_pops - pops_before, 7);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mem_cen", mem_cen, 1'b1);
    chk("rst_mem_wen", mem_wen, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ofifo_rd", ofifo_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 11'h000);
    chk("rst_mem_d", mem_d, '0);
    @(posedge clk); #3;
    src_q.delete();
    reset = 1'b1;
    fill_seq(NIJ, 200);
    run_pass(11'h2A0, 1'b0, 0, 1'b0, 1'b0);
    if (wr_log.size() == NIJ) chk("rst_new_base", wr_log[0], 11'h2A0);

    // Randomized passes.
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < NIJ + $urandom_range(0, 8); k++) src_q.push_back(rand_row());
      run_pass(AW'($urandom), 1'($urandom), 2, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
